register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
Multi-port register file and successor to the single-write, dual-read 8-bit file. Width, depth and read-port count are parametrised. It has two write ports with fixed priority, an optional hardwired zero register, and a per-register pending scoreboard so the datapath controller can detect read-after-write hazards. It sits between the operand-fetch stage and the ALU/writeback paths.

Parameters:
ADDR_WIDTH, 5, address bits; depth REG_N = 2**ADDR_WIDTH
REG_WIDTH, 8, bits per register
READ_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never pending

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers and pending bits
wr0_en  input  1  write port 0 enable
wr0_addr  input  ADDR_WIDTH  write port 0 address
wr0_data  input  REG_WIDTH  write port 0 data
wr1_en  input  1  write port 1 enable (higher priority)
wr1_addr  input  ADDR_WIDTH  write port 1 address
wr1_data  input  REG_WIDTH  write port 1 data
rsv_en  input  1  reserve: mark rsv_addr pending (producer issued)
rsv_addr  input  ADDR_WIDTH  register to reserve
rd_addr  input  READ_PORTS*ADDR_WIDTH  packed read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  READ_PORTS*REG_WIDTH  packed read data, port k at bits [k*REG_WIDTH +: REG_WIDTH]
rd_pending  output  READ_PORTS  bit k high when rd_addr[k] has an outstanding reservation
pending_cnt  output  ADDR_WIDTH+1  registered count of pending registers

Behaviour:
- Reset (async, any time, including mid-operation): all registers 0, all pending bits 0, pending_cnt 0. rd_data therefore reads 0 and rd_pending reads 0 while reset is held. Writes and reserves in the reset cycle are lost.
- Writes: on the rising edge, if wrX_en then reg[wrX_addr] <= wrX_data. Both ports enabled to the same address: port 1 data is stored and port 0 is dropped. Different addresses: both are stored.
- Reads: combinational, zero latency. rd_data[k] = reg[rd_addr[k]] as of the last edge (bypass behaviour is covered under Optional Feature).
- ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0; reserves of address 0 are ignored; rd_pending is 0 for address 0.
- Scoreboard: one pending bit per register, updated on the rising edge.
  - An enabled write (either port) clears the pending bit of its address.
  - rsv_en sets the pending bit of rsv_addr.
  - Reserve and write to the same address in one cycle: the reserve wins and the bit ends set (a new producer supersedes the old).
  - Reserving an already-pending register keeps it set; no error and no count change.
  - A write to a non-pending register only updates data.
- rd_pending[k]: combinational, equal to pending[rd_addr[k]] (before any bypass adjustment).
- pending_cnt: registered; equals the popcount of the pending bits after each edge. Maximum is REG_N, or REG_N-1 when ZERO_REG=1. It never wraps, because ADDR_WIDTH+1 bits hold REG_N.
- No handshake or backpressure; stalling on rd_pending is the controller's job.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If an enabled write port targets rd_addr[k] in the current cycle, rd_data[k] returns that write's data combinationally, with port 1 taking priority over port 0, and rd_pending[k] reads 0 for that cycle unless rsv_en targets the same address. Zero-register rule still applies.
- Undefined: rd_data and rd_pending reflect only state stored at the last edge; the written value is visible one cycle later.

Test Plan:
- Reset mid-traffic: write reg5=0xA5, reserve reg7, assert reset for 1 cycle → rd_data of 5 and 7 = 0x00, rd_pending=0, pending_cnt=0 immediately.
- Write/read all ports: write reg3=0x3C on port 0 and reg9=0xC3 on port 1 in the same cycle; next cycle read ports 0/1 at 3/9 → 0x3C/0xC3.
- Port priority: wr0 and wr1 both to reg4 with 0x11 and 0x22 → reg4 reads 0x22.
- Zero register (ZERO_REG=1): write reg0=0xFF and reserve reg0 → reads 0x00, rd_pending=0, pending_cnt unchanged.
- Scoreboard: reserve reg6 → pending_cnt=1 and rd_pending set; next cycle reserve reg6 while wr0 writes reg6=0x55 → still pending, count 1, reg6=0x55; next cycle write reg6 alone → count 0.
- Bypass (macro defined): reg2 holds 0x10, then in the same cycle wr1 writes reg2=0x77 while read port 1 addresses reg2 → rd_data=0x77 that cycle. Macro undefined → 0x10 that cycle, 0x77 the next.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports, N read ports, pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module register_file_mp_rd_lane #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 8,
  parameter int ZERO_REG   = 1
) (
  input  logic [2**ADDR_WIDTH-1:0][REG_WIDTH-1:0] regs,
  input  logic [2**ADDR_WIDTH-1:0]                pending,
  input  logic [ADDR_WIDTH-1:0]                   addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                                    reset,
  input  logic [1:0]                              wr_en,
  input  logic [1:0][ADDR_WIDTH-1:0]              wr_addr,
  input  logic [1:0][REG_WIDTH-1:0]               wr_data,
  input  logic                                    rsv_en,
  input  logic [ADDR_WIDTH-1:0]                   rsv_addr,
`endif
  output logic [REG_WIDTH-1:0]                    data,
  output logic                                    pend
);
  always_comb begin
    data = regs[addr];
    pend = pending[addr];
`ifdef REGFILE_BYPASS_EN
    // Port 1 is visited last so it overrides port 0 on an address collision.
    if (!reset && (ZERO_REG == 0 || addr != '0)) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p] == addr) begin
          data = wr_data[p];
          pend = rsv_en && (rsv_addr == addr);
        end
      end
    end
`endif
  end
endmodule

module register_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 8,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr0_en,
  input  logic [ADDR_WIDTH-1:0]            wr0_addr,
  input  logic [REG_WIDTH-1:0]             wr0_data,
  input  logic                             wr1_en,
  input  logic [ADDR_WIDTH-1:0]            wr1_addr,
  input  logic [REG_WIDTH-1:0]             wr1_data,
  input  logic                             rsv_en,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS*REG_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]            rd_pending,
  output logic [ADDR_WIDTH:0]              pending_cnt
);
  localparam int REG_N = 2**ADDR_WIDTH;

  logic [REG_N-1:0][REG_WIDTH-1:0] regs, regs_nxt;
  logic [REG_N-1:0]                pending, pend_nxt;
  logic [ADDR_WIDTH:0]             cnt_nxt;
  logic [1:0]                      wr_en;
  logic [1:0][ADDR_WIDTH-1:0]      wr_addr;
  logic [1:0][REG_WIDTH-1:0]       wr_data;

  assign wr_en   = {wr1_en, wr0_en};
  assign wr_addr = {wr1_addr, wr0_addr};
  assign wr_data = {wr1_data, wr0_data};

  // Apply port 0, then port 1, then the reserve: later updates win.
  always_comb begin
    regs_nxt = regs;
    pend_nxt = pending;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        regs_nxt[wr_addr[p]] = wr_data[p];
        pend_nxt[wr_addr[p]] = 1'b0;
      end
    end
    if (rsv_en) pend_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      regs_nxt[0] = '0;
      pend_nxt[0] = 1'b0;
    end
    cnt_nxt = '0;
    for (int i = 0; i < REG_N; i++)
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs        <= '0;
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      regs        <= regs_nxt;
      pending     <= pend_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    register_file_mp_rd_lane #(
      .ADDR_WIDTH(ADDR_WIDTH), .REG_WIDTH(REG_WIDTH), .ZERO_REG(ZERO_REG)
    ) u_lane (
      .regs    (regs),
      .pending (pending),
      .addr    (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
`ifdef REGFILE_BYPASS_EN
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
`endif
      .data    (rd_data[k*REG_WIDTH +: REG_WIDTH]),
      .pend    (rd_pending[k])
    );
  end
endmodule
